// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell processes one bit per clock, LSB first.
// Operands load on start; S/Cout update once per operation and hold until the next result.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_s;
    logic             r_sub;
    logic             r_c;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_a;
    logic             w_b;
    logic             w_bit;
    logic             w_cnext;
    logic             w_last;
    logic             w_load;

    assign w_a     = r_a[0];
    assign w_b     = r_b[0];
    assign w_bit   = w_a ^ w_b ^ r_c;
    assign w_cnext = r_sub ? ((~w_a & w_b) | (r_c & ~(w_a ^ w_b)))
                           : ((w_a & w_b) | (r_c & (w_a ^ w_b)));
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    // start is honoured in IDLE and in DONE (back-to-back), never while shifting.
    assign w_load  = (r_state != SHIFT) && start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_s    <= '0;
            r_sub  <= 1'b0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_sub <= Sub;
            r_c   <= Cin;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_bit, r_res[WIDTH-1:1]};
            r_c   <= w_cnext;
            r_cnt <= r_cnt + 1'b1;
            // Outputs are published only with the final bit so partial sums never show.
            if (w_last) begin
                r_s    <= {w_bit, r_res[WIDTH-1:1]};
                r_cout <= w_cnext;
            end
        end
    end

    assign busy        = (r_state == SHIFT);
    assign done        = (r_state == DONE);
    assign S           = r_s;
    assign Cout        = r_cout;
    assign o_dbg_state = r_state;

endmodule
